// File: rtl/bit_reverse_reorder_buffer_pkg.sv
// Shared constants and helpers for the bit-reversed to natural-order reorder buffer.
// Holds the architecture tag, legal frame-size bounds and frame-length math.
package bit_reverse_reorder_buffer_pkg;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";

  localparam int FRAME_BITS_MIN = 1;
  localparam int FRAME_BITS_MAX = 12;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic int frame_len(input int b);
    return 1 << b;
  endfunction

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

endpackage

// File: rtl/bit_reverse_reorder_buffer_if.sv
// Stream bundle for the reorder buffer: bit-reversed input side and natural-order output side.
// The slave modport is the buffer itself; master is the surrounding producer/consumer.
interface bit_reverse_reorder_buffer_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/bit_reverse_reorder_buffer_bit_reorder.sv
// Combinational bit-order reversal of a DATA_WIDTH-bit word (MSB <-> LSB).
// Used by the reorder buffer to turn its write counter into a bit-reversed address.
module bit_reorder #(
  parameter int DATA_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_rev
    assign o_data[g] = i_data[DATA_WIDTH-1-g];
  end

endmodule

// File: rtl/bit_reverse_reorder_buffer.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed index order, leave in natural order.
// One bank fills while the other drains, sustaining one sample per clock in each direction.
module bit_reverse_reorder_buffer
  import bit_reverse_reorder_buffer_pkg::*;
#(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    DATA_WIDTH   = 32,
  parameter int    FRAME_BITS   = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  bit_reverse_reorder_buffer_if.slave    io_stream
);

  localparam int                    N        = frame_len(FRAME_BITS);
  localparam logic [FRAME_BITS-1:0] LAST_IDX = FRAME_BITS'(N - 1);
  localparam logic [FRAME_BITS-1:0] CNT_ONE  = FRAME_BITS'(1);

  if (ARCHITECTURE != ARCH_BEHAVIORAL) begin : g_bad_arch
    $error("bit_reverse_reorder_buffer: unsupported ARCHITECTURE");
  end
  if (FRAME_BITS < FRAME_BITS_MIN || FRAME_BITS > FRAME_BITS_MAX) begin : g_bad_frame
    $error("bit_reverse_reorder_buffer: FRAME_BITS out of range");
  end

  bank_e                  r_wr_bank;
  bank_e                  r_rd_bank;
  logic [FRAME_BITS-1:0]  r_wr_cnt;
  logic [FRAME_BITS-1:0]  r_rd_cnt;
  logic [1:0]             r_bank_full;
  logic [DATA_WIDTH-1:0]  r_mem [2][N];

  logic [FRAME_BITS-1:0]  w_wr_addr;
  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_wr_fire;
  logic                   w_rd_fire;
  logic                   w_wr_done;
  logic                   w_rd_done;
  logic [1:0]             w_bank_full_nxt;

  bit_reorder #(
    .DATA_WIDTH (FRAME_BITS)
  ) u_wr_addr_rev (
    .i_data (r_wr_cnt),
    .o_data (w_wr_addr)
  );

  assign w_in_ready  = ~r_bank_full[r_wr_bank];
  assign w_out_valid = r_bank_full[r_rd_bank];
  assign w_wr_fire   = io_stream.in_valid & w_in_ready;
  assign w_rd_fire   = w_out_valid & io_stream.out_ready;
  assign w_wr_done   = w_wr_fire & (r_wr_cnt == LAST_IDX);
  assign w_rd_done   = w_rd_fire & (r_rd_cnt == LAST_IDX);

  // Fill and drain always target different banks, so set and clear never collide.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_done) w_bank_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_done) w_bank_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_bank   <= BANK_0;
      r_rd_bank   <= BANK_0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_bank_full <= 2'b00;
    end else begin
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + CNT_ONE;
        if (w_wr_done) r_wr_bank <= other_bank(r_wr_bank);
      end
      if (w_rd_fire) begin
        r_rd_cnt <= r_rd_cnt + CNT_ONE;
        if (w_rd_done) r_rd_bank <= other_bank(r_rd_bank);
      end
      r_bank_full <= w_bank_full_nxt;
    end
  end

  // Sample storage is deliberately not reset; bank_full alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_fire) begin
      r_mem[r_wr_bank][w_wr_addr] <= io_stream.in_data;
    end
  end

  assign io_stream.in_ready  = w_in_ready;
  assign io_stream.out_valid = w_out_valid;
  assign io_stream.out_data  = r_mem[r_rd_bank][r_rd_cnt];
  assign io_stream.out_last  = w_out_valid & (r_rd_cnt == LAST_IDX);

endmodule

// File: tb/tb_bit_reverse_reorder_buffer.sv
// Directed bench for the reorder buffer: an 8-point 32-bit instance and a 2-point 8-bit instance.
module tb_bit_reverse_reorder_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int br3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  bit_reverse_reorder_buffer_if #(.DATA_WIDTH(32)) bus_a ();
  bit_reverse_reorder_buffer_if #(.DATA_WIDTH(8))  bus_b ();

  bit_reverse_reorder_buffer #(
    .ARCHITECTURE ("BEHAVIORAL"),
    .DATA_WIDTH   (32),
    .FRAME_BITS   (3)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_stream (bus_a.slave)
  );

  bit_reverse_reorder_buffer #(
    .ARCHITECTURE ("BEHAVIORAL"),
    .DATA_WIDTH   (8),
    .FRAME_BITS   (1)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_stream (bus_b.slave)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // A write must never land in the bank the read side still holds as full.
  always @(posedge clk) begin
    if (rst_n && bus_a.in_valid && bus_a.in_ready) begin
      expect_eq("wr_rd_bank_clash",
                32'((dut_a.r_wr_bank == dut_a.r_rd_bank) && dut_a.r_bank_full[dut_a.r_rd_bank]),
                32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oi, lasts, wi, ri, r;
    logic        held_v;
    logic [31:0] held_d;

    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    expect_eq("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
    expect_eq("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    expect_eq("rst_out_last",  32'(bus_a.out_last),  32'd0);
    expect_eq("rst_b_ready",   32'(bus_b.in_ready),  32'd1);
    expect_eq("rst_b_valid",   32'(bus_b.out_valid), 32'd0);

    // 1: single frame, bit-reversed in, natural out
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      expect_eq("t1_in_ready", 32'(bus_a.in_ready), 32'd1);
      expect_eq("t1_early_valid", 32'(bus_a.out_valid), 32'd0);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 32'(br3[i]);
    end
    cyc();
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      expect_eq("t1_valid", 32'(bus_a.out_valid), 32'd1);
      expect_eq("t1_data",  bus_a.out_data, 32'(k));
      expect_eq("t1_last",  32'(bus_a.out_last), 32'(k == 7));
    end
    cyc();
    expect_eq("t1_idle", 32'(bus_a.out_valid), 32'd0);

    // 2: both banks fill with the consumer stalled, then drain
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      expect_eq("t2_in_ready", 32'(bus_a.in_ready), 32'd1);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 32'('h100 * (i / 8 + 1) + br3[i % 8]);
    end
    cyc();
    expect_eq("t2_full_ready", 32'(bus_a.in_ready), 32'd0);
    bus_a.in_data = 32'hBAD0_0017;
    cyc();
    expect_eq("t2_still_full", 32'(bus_a.in_ready), 32'd0);
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      expect_eq("t2_a_data",  bus_a.out_data, 32'('h100 + k));
      expect_eq("t2_a_last",  32'(bus_a.out_last), 32'(k == 7));
      expect_eq("t2_a_ready", 32'(bus_a.in_ready), 32'd0);
    end
    cyc();
    expect_eq("t2_ready_back", 32'(bus_a.in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      expect_eq("t2_b_valid", 32'(bus_a.out_valid), 32'd1);
      expect_eq("t2_b_data",  bus_a.out_data, 32'('h200 + k));
      expect_eq("t2_b_last",  32'(bus_a.out_last), 32'(k == 7));
    end
    cyc();
    expect_eq("t2_idle", 32'(bus_a.out_valid), 32'd0);

    // 3: four frames streamed back to back
    oi = 0; lasts = 0;
    for (int c = 0; c < 44; c++) begin
      cyc();
      if (bus_a.out_last) lasts++;
      if (bus_a.out_valid) begin
        expect_eq("t3_data", bus_a.out_data, 32'('h300 + (oi / 8) * 16 + oi % 8));
        expect_eq("t3_last", 32'(bus_a.out_last), 32'(oi % 8 == 7));
        oi++;
      end
      if (c < 32) begin
        expect_eq("t3_in_ready", 32'(bus_a.in_ready), 32'd1);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 32'('h300 + (c / 8) * 16 + br3[c % 8]);
      end else begin
        bus_a.in_valid = 1'b0;
      end
    end
    expect_eq("t3_out_count",  32'(oi),    32'd32);
    expect_eq("t3_last_count", 32'(lasts), 32'd4);

    // 4: reset after five samples discards the partial frame
    for (int i = 0; i < 5; i++) begin
      cyc();
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 32'hDEAD_0000 + 32'(i);
    end
    cyc();
    bus_a.in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    expect_eq("t4_rst_valid", 32'(bus_a.out_valid), 32'd0);
    expect_eq("t4_rst_ready", 32'(bus_a.in_ready),  32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      expect_eq("t4_no_valid", 32'(bus_a.out_valid), 32'd0);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 32'('h400 + br3[i]);
    end
    cyc();
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      expect_eq("t4_valid", 32'(bus_a.out_valid), 32'd1);
      expect_eq("t4_data",  bus_a.out_data, 32'('h400 + k));
      expect_eq("t4_last",  32'(bus_a.out_last), 32'(k == 7));
    end
    cyc();
    expect_eq("t4_idle", 32'(bus_a.out_valid), 32'd0);

    // 5: random consumer backpressure over three frames
    wi = 0; ri = 0; held_v = 1'b0; held_d = '0;
    for (int c = 0; c < 400 && ri < 24; c++) begin
      cyc();
      if (held_v) begin
        expect_eq("t5_hold_valid", 32'(bus_a.out_valid), 32'd1);
        expect_eq("t5_hold_data",  bus_a.out_data, held_d);
      end
      if (bus_a.out_valid) begin
        expect_eq("t5_data", bus_a.out_data, 32'('h500 + (ri / 8) * 16 + ri % 8));
        expect_eq("t5_last", 32'(bus_a.out_last), 32'(ri % 8 == 7));
      end
      r = int'($urandom_range(0, 1));
      bus_a.out_ready = (r == 1);
      held_v = bus_a.out_valid && (r == 0);
      held_d = bus_a.out_data;
      if (bus_a.out_valid && r == 1) ri++;
      if (wi < 24) begin
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 32'('h500 + (wi / 8) * 16 + br3[wi % 8]);
        if (bus_a.in_ready) wi++;
      end else begin
        bus_a.in_valid = 1'b0;
      end
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    expect_eq("t5_written", 32'(wi), 32'd24);
    expect_eq("t5_read",    32'(ri), 32'd24);
    cyc();
    expect_eq("t5_idle", 32'(bus_a.out_valid), 32'd0);

    // 6: two-entry instance, bit reversal is the identity
    bus_b.out_ready = 1'b1;
    cyc();
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 8'hAA;
    cyc();
    expect_eq("t6_mid_valid", 32'(bus_b.out_valid), 32'd0);
    bus_b.in_data  = 8'h55;
    cyc();
    bus_b.in_valid = 1'b0;
    expect_eq("t6_valid0", 32'(bus_b.out_valid), 32'd1);
    expect_eq("t6_data0",  32'(bus_b.out_data),  32'h0AA);
    expect_eq("t6_last0",  32'(bus_b.out_last),  32'd0);
    cyc();
    expect_eq("t6_valid1", 32'(bus_b.out_valid), 32'd1);
    expect_eq("t6_data1",  32'(bus_b.out_data),  32'h055);
    expect_eq("t6_last1",  32'(bus_b.out_last),  32'd1);
    cyc();
    expect_eq("t6_idle", 32'(bus_b.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
